// File: rtl/bert_pkg.sv
// Shared bit-error-tester definitions: PRBS-7 pattern, checker FSM states and
// counter widths, used by both the pattern generator and the error checker.
package bert_pkg;

  localparam int PRBS_W       = 7;
  localparam int SEED_CNT_W   = 3;
  localparam int ERR_CNT_W    = 16;
  localparam int BCD_W        = 16;
  localparam int BIT_CNT_W    = 32;
  localparam int RESYNC_CNT_W = 8;

  // x^7 + x^6 + 1: the predicted bit is s[6] ^ s[5]
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 7'b110_0000;
  localparam logic [BCD_W-1:0]  BCD_MAX   = 16'h9999;

  typedef logic [PRBS_W-1:0] prbs_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } chk_state_t;

  function automatic logic prbs_predict(input prbs_state_t s);
    return ^(s & PRBS_TAPS);
  endfunction

  function automatic prbs_state_t prbs_next(input prbs_state_t s);
    return {s[PRBS_W-2:0], prbs_predict(s)};
  endfunction

endpackage

// File: rtl/bcd_counter_4digit.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 instead of
// wrapping so the display never shows a misleadingly small total.
module bcd_counter_4digit
  import bert_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [BCD_W-1:0] value
);

  logic [BCD_W-1:0] value_inc;
  logic             carry;

  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != BCD_MAX)) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/prbs_error_checker.sv
// PRBS-7 receive-side error checker: seeds its LFSR from the incoming stream,
// then counts mismatches and drops back to seeding when errors pile up.
//
// state    | meaning
// ST_IDLE  | disabled, nothing consumed
// ST_SEED  | shifting 7 received bits into the LFSR
// ST_CHECK | locked, comparing each received bit with the prediction
module prbs_error_checker
  import bert_pkg::*;
#(
  parameter int WINDOW_BITS    = 64,
  parameter int LOSS_THRESHOLD = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    data_rx,
  output logic                    locked,
  output logic                    error_pulse,
  output logic [ERR_CNT_W-1:0]    error_count,
  output logic [BCD_W-1:0]        error_bcd,
  output logic [BIT_CNT_W-1:0]    bit_count,
  output logic [RESYNC_CNT_W-1:0] resync_count
);

  localparam int WIN_W = $clog2(WINDOW_BITS + 1);
  localparam int THR_W = $clog2(LOSS_THRESHOLD + 1);

  chk_state_t             state, state_nxt;
  prbs_state_t            lfsr, lfsr_nxt;
  logic [SEED_CNT_W-1:0]  seed_cnt, seed_cnt_nxt;
  logic [WIN_W-1:0]       win_bits;
  logic [THR_W-1:0]       win_errs;

  logic                   check_cycle;
  logic                   bit_err;
  logic                   lose_lock;
  logic [WIN_W-1:0]       win_bits_inc;
  logic [THR_W-1:0]       win_err_sum;

  assign check_cycle  = enable && (state == ST_CHECK);
  assign bit_err      = check_cycle && (data_rx != prbs_predict(lfsr));
  assign win_bits_inc = win_bits + WIN_W'(1);
  assign win_err_sum  = win_errs + THR_W'(bit_err);
  assign lose_lock    = check_cycle && (win_err_sum >= THR_W'(LOSS_THRESHOLD));
  assign locked       = (state == ST_CHECK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lfsr     <= '0;
      seed_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lfsr     <= lfsr_nxt;
      seed_cnt <= seed_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lfsr_nxt     = lfsr;
    seed_cnt_nxt = seed_cnt;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt    = ST_SEED;
          seed_cnt_nxt = '0;
        end
        ST_SEED: begin
          lfsr_nxt = {lfsr[PRBS_W-2:0], data_rx};
          if (seed_cnt == SEED_CNT_W'(PRBS_W - 1)) begin
            seed_cnt_nxt = '0;
            // an all-zero seed would lock the LFSR at zero forever
            if (lfsr_nxt != '0) state_nxt = ST_CHECK;
          end else begin
            seed_cnt_nxt = seed_cnt + SEED_CNT_W'(1);
          end
        end
        ST_CHECK: begin
          lfsr_nxt = prbs_next(lfsr);
          if (lose_lock) begin
            state_nxt    = ST_SEED;
            seed_cnt_nxt = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Window counters only live while checking; any exit from CHECK zeroes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_bits <= '0;
      win_errs <= '0;
    end else if (!check_cycle || lose_lock || (win_bits_inc == WIN_W'(WINDOW_BITS))) begin
      win_bits <= '0;
      win_errs <= '0;
    end else begin
      win_bits <= win_bits_inc;
      win_errs <= win_err_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_pulse  <= 1'b0;
      error_count  <= '0;
      bit_count    <= '0;
      resync_count <= '0;
    end else begin
      error_pulse <= bit_err;
      if (clear) begin
        error_count  <= '0;
        bit_count    <= '0;
        resync_count <= '0;
      end else begin
        if (bit_err && (error_count != '1))      error_count  <= error_count + ERR_CNT_W'(1);
        if (check_cycle && (bit_count != '1))    bit_count    <= bit_count + BIT_CNT_W'(1);
        if (lose_lock && (resync_count != '1))   resync_count <= resync_count + RESYNC_CNT_W'(1);
      end
    end
  end

  bcd_counter_4digit u_bcd (
    .clk   (clk),
    .reset (reset),
    .inc   (bit_err),
    .clear (clear),
    .value (error_bcd)
  );

endmodule

// File: tb/tb_prbs_error_checker.sv
// Bench for prbs_error_checker: scenario tasks checked against a bit-history
// reference model of the acquisition and error-counting rules.
module tb_prbs_error_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        data_rx;
  logic        locked;
  logic        error_pulse;
  logic [15:0] error_count;
  logic [15:0] error_bcd;
  logic [31:0] bit_count;
  logic [7:0]  resync_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit     m_active;
  bit     m_locked;
  bit     m_pulse;
  int     m_nseed;
  bit     q[$];
  int     m_err;
  longint m_bits;
  int     m_resync;
  int     m_werr;
  int     m_wbits;

  bit [6:0] gen = 7'h5A;

  always #5 clk = ~clk;

  prbs_error_checker dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .data_rx      (data_rx),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .error_count  (error_count),
    .error_bcd    (error_bcd),
    .bit_count    (bit_count),
    .resync_count (resync_count)
  );

  function automatic bit gen_bit();
    bit b;
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
    return b;
  endfunction

  // q[0] is the bit seven back, q[1] the bit six back
  function automatic bit pred();
    return q[0] ^ q[1];
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    logic [15:0] r;
    int c;
    c = (v > 9999) ? 9999 : v;
    r[15:12] = 4'(c / 1000);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_pulse = 0; m_nseed = 0;
    q = '{0, 0, 0, 0, 0, 0, 0};
    m_err = 0; m_bits = 0; m_resync = 0; m_werr = 0; m_wbits = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit d);
    bit p;
    int ones;
    m_pulse = 0;
    if (!en) begin
      m_active = 0; m_locked = 0; m_werr = 0; m_wbits = 0;
    end else if (!m_active) begin
      m_active = 1; m_nseed = 0;
    end else if (!m_locked) begin
      q.push_back(d);
      void'(q.pop_front());
      m_nseed++;
      if (m_nseed == 7) begin
        m_nseed = 0;
        ones = 0;
        foreach (q[i]) ones += int'(q[i]);
        if (ones != 0) m_locked = 1;
      end
    end else begin
      p = pred();
      q.push_back(p);
      void'(q.pop_front());
      m_pulse = (d != p);
      if (m_bits < 64'hFFFF_FFFF) m_bits++;
      if (m_pulse && m_err < 65535) m_err++;
      m_werr += int'(m_pulse);
      m_wbits++;
      if (m_werr >= 8) begin
        m_locked = 0; m_nseed = 0;
        if (m_resync < 255) m_resync++;
        m_werr = 0; m_wbits = 0;
      end else if (m_wbits == 64) begin
        m_werr = 0; m_wbits = 0;
      end
    end
    if (clr) begin
      m_err = 0; m_bits = 0; m_resync = 0;
    end
  endtask

  task automatic clk_step(input bit en, input bit clr, input bit d);
    enable  = en;
    clear   = clr;
    data_rx = d;
    @(posedge clk);
    model_step(en, clr, d);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; enable = 0; clear = 0; data_rx = 0;
    model_reset();
    #2;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
    total++; if (error_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", error_pulse); end
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", error_count); end
    total++; if (error_bcd !== 16'h0) begin bad++; $display("FAIL reset_bcd got=%h want=0000", error_bcd); end
    total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL reset_bits got=%0d want=0", bit_count); end
    total++; if (resync_count !== 8'd0) begin bad++; $display("FAIL reset_resync got=%0d want=0", resync_count); end
    @(negedge clk);
    reset = 1;
    clk_step(0, 0, 0);
  endtask

  task automatic test_lock_clean();
    clk_step(0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      clk_step(1, 0, gen_bit());
      if (i == 7) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_at8 got=%b want=1", locked); end
    for (int i = 0; i < 1000; i++) clk_step(1, 0, gen_bit());
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL clean_err got=%0d want=0", error_count); end
    total++; if (bit_count !== 32'd1000) begin bad++; $display("FAIL clean_bits got=%0d want=1000", bit_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_locked got=%b want=1", locked); end
  endtask

  task automatic test_isolated_errors();
    int pulses = 0;
    bit inj;
    clk_step(1, 1, gen_bit());
    for (int i = 0; i < 90; i++) begin
      inj = (i == 10) || (i == 40) || (i == 70);
      clk_step(1, 0, gen_bit() ^ inj);
      pulses += int'(error_pulse);
      total++;
      if (error_pulse !== inj) begin bad++; $display("FAIL iso_pulse cyc=%0d got=%b want=%b", i, error_pulse, inj); end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL iso_npulse got=%0d want=3", pulses); end
    total++; if (error_count !== 16'd3) begin bad++; $display("FAIL iso_err got=%0d want=3", error_count); end
    total++; if (error_bcd !== 16'h0003) begin bad++; $display("FAIL iso_bcd got=%h want=0003", error_bcd); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL iso_locked got=%b want=1", locked); end
  endtask

  task automatic test_loss_of_lock();
    clk_step(1, 1, gen_bit());
    for (int i = 0; i < 8; i++) begin
      clk_step(1, 0, ~gen_bit());
      if (i == 6) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lol_early got=%b want=1", locked); end
      end
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lol_drop got=%b want=0", locked); end
    total++; if (resync_count !== 8'd1) begin bad++; $display("FAIL lol_resync got=%0d want=1", resync_count); end
    for (int i = 1; i <= 7; i++) begin
      clk_step(1, 0, gen_bit());
      if (i == 6) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got=%b want=0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock got=%b want=1", locked); end
    for (int i = 0; i < 20; i++) clk_step(1, 0, gen_bit());
    total++; if (error_count !== 16'd8) begin bad++; $display("FAIL relock_err got=%0d want=8", error_count); end
  endtask

  task automatic test_all_zero();
    clk_step(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      clk_step(1, 0, 0);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL zero_locked cyc=%0d got=%b want=0", i, locked); end
    end
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL zero_err got=%0d want=0", error_count); end
    total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL zero_bits got=%0d want=0", bit_count); end
  endtask

  task automatic test_random();
    bit en, clr, d;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(49) != 0);
      clr = ($urandom_range(199) == 0);
      d   = m_locked ? (pred() ^ ($urandom_range(11) == 0)) : 1'($urandom);
      clk_step(en, clr, d);
      total++;
      if (locked !== m_locked || error_pulse !== m_pulse || error_count !== 16'(m_err) ||
          error_bcd !== exp_bcd(m_err) || bit_count !== 32'(m_bits) || resync_count !== 8'(m_resync)) begin
        bad++;
        $display("FAIL rand cyc=%0d got lk=%b ep=%b ec=%0d bcd=%h bc=%0d rs=%0d want lk=%b ep=%b ec=%0d bcd=%h bc=%0d rs=%0d",
                 i, locked, error_pulse, error_count, error_bcd, bit_count, resync_count,
                 m_locked, m_pulse, m_err, exp_bcd(m_err), m_bits, m_resync);
      end
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    clk_step(1, 1, m_locked ? pred() : 1'($urandom));
    while (m_err < 9998 && n < 40000) begin
      clk_step(1, 0, m_locked ? ~pred() : 1'($urandom));
      n++;
    end
    total++; if (m_err != 9998) begin bad++; $display("FAIL sat_preload timeout got=%0d want=9998", m_err); end
    total++; if (error_count !== 16'(m_err)) begin bad++; $display("FAIL sat_pre_err got=%0d want=%0d", error_count, m_err); end
    total++; if (error_bcd !== exp_bcd(m_err)) begin bad++; $display("FAIL sat_pre_bcd got=%h want=%h", error_bcd, exp_bcd(m_err)); end
    total++; if (resync_count !== 8'hFF) begin bad++; $display("FAIL sat_resync got=%0d want=255", resync_count); end
    n = 0;
    while ((!m_locked || n < 100) && n < 1000) begin
      clk_step(1, 0, m_locked ? pred() : 1'($urandom));
      n++;
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL sat_relock got=%b want=1", locked); end
    for (int k = 0; k < 3; k++) begin
      clk_step(1, 0, ~pred());
      for (int i = 0; i < 20; i++) clk_step(1, 0, pred());
    end
    total++; if (error_count !== 16'd10001) begin bad++; $display("FAIL sat_err got=%0d want=10001", error_count); end
    total++; if (error_bcd !== 16'h9999) begin bad++; $display("FAIL sat_bcd got=%h want=9999", error_bcd); end
    clk_step(1, 1, ~pred());
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL clr_err got=%0d want=0", error_count); end
    total++; if (error_bcd !== 16'h0) begin bad++; $display("FAIL clr_bcd got=%h want=0000", error_bcd); end
    total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL clr_bits got=%0d want=0", bit_count); end
    total++; if (resync_count !== 8'd0) begin bad++; $display("FAIL clr_resync got=%0d want=0", resync_count); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_locked got=%b want=1", locked); end
  endtask

  task automatic test_reset_mid_check();
    for (int i = 0; i < 5; i++) clk_step(1, 0, pred() ^ (i == 2));
    #3;
    reset = 0;
    #1;
    model_reset();
    total++;
    if (locked !== 1'b0 || error_pulse !== 1'b0 || error_count !== 16'd0 || error_bcd !== 16'h0 ||
        bit_count !== 32'd0 || resync_count !== 8'd0) begin
      bad++;
      $display("FAIL midreset got lk=%b ep=%b ec=%0d bcd=%h bc=%0d rs=%0d want all 0",
               locked, error_pulse, error_count, error_bcd, bit_count, resync_count);
    end
    @(negedge clk);
    reset = 1;
    for (int i = 1; i <= 8; i++) clk_step(1, 0, gen_bit());
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL midreset_relock got=%b want=1", locked); end
    for (int i = 0; i < 200; i++) clk_step(1, 0, gen_bit());
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL midreset_err got=%0d want=0", error_count); end
    total++; if (bit_count !== 32'd200) begin bad++; $display("FAIL midreset_bits got=%0d want=200", bit_count); end
  endtask

  initial begin
    test_reset();
    test_lock_clean();
    test_isolated_errors();
    test_loss_of_lock();
    test_all_zero();
    test_random();
    test_saturation();
    test_reset_mid_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
